// File: rtl/riscv_pkg.sv
// Shared RV64 pipeline definitions: widths, ALU function encodings and the
// decoded control bundle carried from ID into EX.
package riscv_pkg;

  localparam int XLEN = 64;
  localparam int RAW  = 5;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic alu_src;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // True when a non-x0 destination is read by either source of a consumer.
  function automatic logic src_match(input logic [RAW-1:0] rd,
                                     input logic [RAW-1:0] rs1,
                                     input logic [RAW-1:0] rs2);
    return (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/operand_forward.sv
// Per-source operand bypass: picks the freshest value for one register index,
// preferring the EX/MEM producer over MEM/WB; x0 is never bypassed.
module operand_forward
  import riscv_pkg::*;
(
  input  logic [RAW-1:0]  addr_i,
  input  logic [XLEN-1:0] regData_i,
  input  logic            memRegWrite_i,
  input  logic [RAW-1:0]  memRdAddr_i,
  input  logic [XLEN-1:0] memResult_i,
  input  logic            wbRegWrite_i,
  input  logic [RAW-1:0]  wbRdAddr_i,
  input  logic [XLEN-1:0] wbData_i,
  output logic [XLEN-1:0] fwdData_o
);

  always_comb begin
    fwdData_o = regData_i;
    if (memRegWrite_i && (memRdAddr_i == addr_i) && (addr_i != '0)) begin
      fwdData_o = memResult_i;
    end else if (wbRegWrite_i && (wbRdAddr_i == addr_i) && (addr_i != '0)) begin
      fwdData_o = wbData_i;
    end
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall, flush and load-use bubble insertion.
// Define ID_EX_FWD_EN to enable MEM/WB operand forwarding; otherwise RAW hazards stall instead.
module id_ex_reg
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [2:0]      id_funct3,
  input  logic [6:0]      id_funct7,
  input  logic [RAW-1:0]  id_rs1_addr,
  input  logic [RAW-1:0]  id_rs2_addr,
  input  logic [RAW-1:0]  id_rd_addr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_branch,
  input  logic            id_alu_src,
  input  logic            mem_reg_write,
  input  logic [RAW-1:0]  mem_rd_addr,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_reg_write,
  input  logic [RAW-1:0]  wb_rd_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic [RAW-1:0]  ex_rd_addr,
  output logic [2:0]      ex_funct3,
  output logic [6:0]      ex_funct7,
  output logic [XLEN-1:0] ex_op_a,
  output logic [XLEN-1:0] ex_op_b,
  output logic [XLEN-1:0] ex_store_data,
  output logic            hazard
);

`ifdef ID_EX_FWD_EN
  localparam logic FwdOn = 1'b1;
`else
  localparam logic FwdOn = 1'b0;
`endif

  logic            valid_q,   valid_d;
  ctrl_t           ctrl_q,    ctrl_d;
  logic [RAW-1:0]  rdAddr_q,  rdAddr_d;
  logic [RAW-1:0]  rs1Addr_q, rs1Addr_d;
  logic [RAW-1:0]  rs2Addr_q, rs2Addr_d;
  logic [2:0]      funct3_q,  funct3_d;
  logic [6:0]      funct7_q,  funct7_d;
  logic [XLEN-1:0] rs1Data_q, rs1Data_d;
  logic [XLEN-1:0] rs2Data_q, rs2Data_d;
  logic [XLEN-1:0] imm_q,     imm_d;

  logic            loadUse;
  logic            rawDep;
  logic            bubble;
  logic            load;
  logic [XLEN-1:0] fwdRs1;
  logic [XLEN-1:0] fwdRs2;

  assign loadUse = valid_q & ctrl_q.mem_read & src_match(rdAddr_q, id_rs1_addr, id_rs2_addr);

  // Without bypassing, any in-flight producer that a decode source depends on must drain first.
`ifdef ID_EX_FWD_EN
  assign rawDep = 1'b0;
`else
  assign rawDep = (valid_q & ctrl_q.reg_write & src_match(rdAddr_q, id_rs1_addr, id_rs2_addr))
                | (mem_reg_write & src_match(mem_rd_addr, id_rs1_addr, id_rs2_addr));
`endif

  assign hazard = id_valid & ~flush & (loadUse | rawDep);
  assign bubble = flush | (~stall & hazard);
  assign load   = ~flush & ~stall & ~hazard;

  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    rdAddr_d  = rdAddr_q;
    rs1Addr_d = rs1Addr_q;
    rs2Addr_d = rs2Addr_q;
    funct3_d  = funct3_q;
    funct7_d  = funct7_q;
    rs1Data_d = rs1Data_q;
    rs2Data_d = rs2Data_q;
    imm_d     = imm_q;
    if (bubble) begin
      valid_d   = 1'b0;
      ctrl_d    = CTRL_NONE;
      rdAddr_d  = '0;
      rs1Addr_d = '0;
      rs2Addr_d = '0;
      funct3_d  = '0;
      funct7_d  = '0;
      rs1Data_d = '0;
      rs2Data_d = '0;
      imm_d     = '0;
    end else if (load) begin
      valid_d   = id_valid;
      ctrl_d    = '{reg_write: id_reg_write, mem_read: id_mem_read, mem_write: id_mem_write,
                    branch: id_branch, alu_src: id_alu_src};
      rdAddr_d  = id_rd_addr;
      rs1Addr_d = id_rs1_addr;
      rs2Addr_d = id_rs2_addr;
      funct3_d  = id_funct3;
      // Immediate bits overlap funct7 on I-type; clearing them keeps ADDI from decoding as SUB.
      funct7_d  = id_alu_src ? F7_BASE : id_funct7;
      rs1Data_d = id_rs1_data;
      rs2Data_d = id_rs2_data;
      imm_d     = id_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      ctrl_q    <= CTRL_NONE;
      rdAddr_q  <= '0;
      rs1Addr_q <= '0;
      rs2Addr_q <= '0;
      funct3_q  <= '0;
      funct7_q  <= '0;
      rs1Data_q <= '0;
      rs2Data_q <= '0;
      imm_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      rdAddr_q  <= rdAddr_d;
      rs1Addr_q <= rs1Addr_d;
      rs2Addr_q <= rs2Addr_d;
      funct3_q  <= funct3_d;
      funct7_q  <= funct7_d;
      rs1Data_q <= rs1Data_d;
      rs2Data_q <= rs2Data_d;
      imm_q     <= imm_d;
    end
  end

  operand_forward u_fwd_rs1 (
    .addr_i        (rs1Addr_q),
    .regData_i     (rs1Data_q),
    .memRegWrite_i (mem_reg_write & FwdOn),
    .memRdAddr_i   (mem_rd_addr),
    .memResult_i   (mem_result),
    .wbRegWrite_i  (wb_reg_write & FwdOn),
    .wbRdAddr_i    (wb_rd_addr),
    .wbData_i      (wb_data),
    .fwdData_o     (fwdRs1)
  );

  operand_forward u_fwd_rs2 (
    .addr_i        (rs2Addr_q),
    .regData_i     (rs2Data_q),
    .memRegWrite_i (mem_reg_write & FwdOn),
    .memRdAddr_i   (mem_rd_addr),
    .memResult_i   (mem_result),
    .wbRegWrite_i  (wb_reg_write & FwdOn),
    .wbRdAddr_i    (wb_rd_addr),
    .wbData_i      (wb_data),
    .fwdData_o     (fwdRs2)
  );

  assign ex_valid      = valid_q;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_branch     = ctrl_q.branch;
  assign ex_rd_addr    = rdAddr_q;
  assign ex_funct3     = funct3_q;
  assign ex_funct7     = funct7_q;
  assign ex_op_a       = fwdRs1;
  assign ex_op_b       = ctrl_q.alu_src ? imm_q : fwdRs2;
  assign ex_store_data = fwdRs2;

endmodule
